// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors match scorer: hands, round results,
// winner codes and the match FSM states.
package rps_pkg;

  localparam logic [1:0] ROCK     = 2'b00;
  localparam logic [1:0] PAPER    = 2'b01;
  localparam logic [1:0] SCISORS  = 2'b10;
  localparam logic [1:0] HAND_BAD = 2'b11;

  typedef enum logic [1:0] {
    RES_DRAW  = 2'b00,
    RES_A_WIN = 2'b01,
    RES_B_WIN = 2'b10,
    RES_ERROR = 2'b11
  } res_e;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_A     = 2'b01,
    WIN_B     = 2'b10,
    WIN_ABORT = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic hand_legal(input logic [1:0] h);
    return h != HAND_BAD;
  endfunction

endpackage

// File: rtl/rps_round_classifier.sv
// Maps one judged round to a result code; an illegal hand or judge error outranks
// a draw, which outranks the judge's win flag.
module rps_round_classifier
  import rps_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       is_a_win,
  input  logic       is_error,
  output res_e       res
);

  always_comb begin
    res = RES_B_WIN;
    if (is_error || !hand_legal(a) || !hand_legal(b)) res = RES_ERROR;
    else if (a == b)                                  res = RES_DRAW;
    else if (is_a_win)                                res = RES_A_WIN;
  end

endmodule

// File: rtl/rps_match_scorer.sv
// Match-level scorer for judged RPS rounds: points, draws, errors, draw-streak abort.
// Define RPS_SCORER_HISTORY_EN to add a 16-bit shift register of recent round codes.
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int MAX_DRAWS  = 4,
  parameter int SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               round_valid,
  output logic               round_ready,
  input  logic [1:0]         A,
  input  logic [1:0]         B,
  input  logic               is_A_win,
  input  logic               is_error,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [SCORE_W-1:0] draw_count,
  output logic [SCORE_W-1:0] error_count,
  output logic               match_done,
  output logic [1:0]         winner
`ifdef RPS_SCORER_HISTORY_EN
  ,
  output logic [15:0]        history
`endif
);

  localparam int STREAK_W = $clog2(MAX_DRAWS + 1);
  localparam logic [SCORE_W-1:0]  WIN_T    = SCORE_W'(WIN_TARGET);
  localparam logic [STREAK_W-1:0] DRAW_LIM = STREAK_W'(MAX_DRAWS);

  state_e               state_q, state_d;
  winner_e              winner_q, winner_d;
  logic [SCORE_W-1:0]   score_a_q, score_a_d, score_b_q, score_b_d;
  logic [SCORE_W-1:0]   draw_q, draw_d, err_q, err_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic                 ready_q, ready_d, done_q, done_d;
  logic                 accept;
  res_e                 res;
`ifdef RPS_SCORER_HISTORY_EN
  logic [15:0]          hist_q, hist_d;
`endif

  rps_round_classifier u_cls (
    .a        (A),
    .b        (B),
    .is_a_win (is_A_win),
    .is_error (is_error),
    .res      (res)
  );

  assign accept = round_valid && (state_q == PLAY);

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    draw_d    = draw_q;
    err_d     = err_q;
    streak_d  = streak_q;
`ifdef RPS_SCORER_HISTORY_EN
    hist_d    = hist_q;
`endif
    // start takes precedence: a round offered alongside it is dropped
    if (start) begin
      state_d   = PLAY;
      winner_d  = WIN_NONE;
      score_a_d = '0;
      score_b_d = '0;
      draw_d    = '0;
      err_d     = '0;
      streak_d  = '0;
`ifdef RPS_SCORER_HISTORY_EN
      hist_d    = '0;
`endif
    end else if (accept) begin
`ifdef RPS_SCORER_HISTORY_EN
      hist_d = {hist_q[13:0], res};
`endif
      unique case (res)
        RES_ERROR: if (err_q != '1) err_d = err_q + 1'b1;
        RES_DRAW: begin
          if (draw_q != '1) draw_d = draw_q + 1'b1;
          streak_d = streak_q + 1'b1;
          if (streak_q + 1'b1 == DRAW_LIM) begin
            state_d  = DONE;
            winner_d = WIN_ABORT;
          end
        end
        RES_A_WIN: begin
          score_a_d = score_a_q + 1'b1;
          streak_d  = '0;
          if (score_a_q + 1'b1 == WIN_T) begin
            state_d  = DONE;
            winner_d = WIN_A;
          end
        end
        RES_B_WIN: begin
          score_b_d = score_b_q + 1'b1;
          streak_d  = '0;
          if (score_b_q + 1'b1 == WIN_T) begin
            state_d  = DONE;
            winner_d = WIN_B;
          end
        end
      endcase
    end
    // status flags follow the next state so they are flop outputs, not decodes
    ready_d = (state_d == PLAY);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      winner_q  <= WIN_NONE;
      score_a_q <= '0;
      score_b_q <= '0;
      draw_q    <= '0;
      err_q     <= '0;
      streak_q  <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef RPS_SCORER_HISTORY_EN
      hist_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      draw_q    <= draw_d;
      err_q     <= err_d;
      streak_q  <= streak_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
`ifdef RPS_SCORER_HISTORY_EN
      hist_q    <= hist_d;
`endif
    end
  end

  assign round_ready = ready_q;
  assign match_done  = done_q;
  assign winner      = winner_q;
  assign score_a     = score_a_q;
  assign score_b     = score_b_q;
  assign draw_count  = draw_q;
  assign error_count = err_q;
`ifdef RPS_SCORER_HISTORY_EN
  assign history     = hist_q;
`endif

endmodule

// File: tb/tb_rps_match_scorer.sv
// Scoreboard bench for rps_match_scorer: driver steps a match model and queues the
// expected outputs per cycle; a monitor on the falling edge pops and compares.
module tb_rps_match_scorer;

  localparam int WIN_TARGET = 3;
  localparam int MAX_DRAWS  = 4;
  localparam int SCORE_W    = 4;
  localparam int SAT        = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic reset, start, round_valid, is_A_win, is_error;
  logic [1:0] A, B;
  logic round_ready, match_done;
  logic [1:0] winner;
  logic [SCORE_W-1:0] score_a, score_b, draw_count, error_count;
  logic [15:0] history;

  always #5 clk = ~clk;

  rps_match_scorer #(.WIN_TARGET(WIN_TARGET), .MAX_DRAWS(MAX_DRAWS), .SCORE_W(SCORE_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .round_valid (round_valid),
    .round_ready (round_ready),
    .A           (A),
    .B           (B),
    .is_A_win    (is_A_win),
    .is_error    (is_error),
    .score_a     (score_a),
    .score_b     (score_b),
    .draw_count  (draw_count),
    .error_count (error_count),
    .match_done  (match_done),
    .winner      (winner)
`ifdef RPS_SCORER_HISTORY_EN
    ,
    .history     (history)
`endif
  );

`ifndef RPS_SCORER_HISTORY_EN
  assign history = 16'h0;
`endif

  typedef struct {
    int sa, sb, dc, ec, win, hist;
    bit rdy, done;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;

  // Reference model: match phase as a string, counts as plain integers
  string m_phase;
  int m_sa, m_sb, m_dc, m_ec, m_streak, m_win, m_hist;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic bit beats(input logic [1:0] x, input logic [1:0] y);
    return (x == 2'd0 && y == 2'd2) || (x == 2'd1 && y == 2'd0) || (x == 2'd2 && y == 2'd1);
  endfunction

  task automatic model_clear();
    m_sa = 0; m_sb = 0; m_dc = 0; m_ec = 0; m_streak = 0; m_win = 0; m_hist = 0;
  endtask

  task automatic model_update(input bit rst, input bit st, input bit v, input logic [1:0] a,
                              input logic [1:0] b, input bit aw, input bit er);
    int code;
    if (rst) begin
      model_clear();
      m_phase = "IDLE";
    end else if (st) begin
      model_clear();
      m_phase = "PLAY";
    end else if (m_phase == "PLAY" && v) begin
      if (er || a == 2'd3 || b == 2'd3) begin
        code = 3;
        if (m_ec < SAT) m_ec++;
      end else if (a == b) begin
        code = 0;
        if (m_dc < SAT) m_dc++;
        m_streak++;
        if (m_streak == MAX_DRAWS) begin m_phase = "DONE"; m_win = 3; end
      end else if (aw) begin
        code = 1;
        m_sa++;
        m_streak = 0;
        if (m_sa == WIN_TARGET) begin m_phase = "DONE"; m_win = 1; end
      end else begin
        code = 2;
        m_sb++;
        m_streak = 0;
        if (m_sb == WIN_TARGET) begin m_phase = "DONE"; m_win = 2; end
      end
      m_hist = ((m_hist << 2) | code) & 16'hFFFF;
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit v, input logic [1:0] a,
                      input logic [1:0] b, input bit aw, input bit er);
    exp_t e;
    reset = rst; start = st; round_valid = v; A = a; B = b; is_A_win = aw; is_error = er;
    @(posedge clk);
    model_update(rst, st, v, a, b, aw, er);
    e.sa = m_sa; e.sb = m_sb; e.dc = m_dc; e.ec = m_ec; e.win = m_win; e.hist = m_hist;
    e.rdy = (m_phase == "PLAY");
    e.done = (m_phase == "DONE");
    expq.push_back(e);
    @(negedge clk);
  endtask

  // legal round helpers: judge flag derived from the hands
  task automatic play(input logic [1:0] a, input logic [1:0] b);
    step(0, 0, 1, a, b, beats(a, b), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("score_a", int'(score_a), e.sa);
      chk("score_b", int'(score_b), e.sb);
      chk("draw_count", int'(draw_count), e.dc);
      chk("error_count", int'(error_count), e.ec);
      chk("winner", int'(winner), e.win);
      chk("round_ready", int'(round_ready), int'(e.rdy));
      chk("match_done", int'(match_done), int'(e.done));
`ifdef RPS_SCORER_HISTORY_EN
      chk("history", int'(history), e.hist);
`endif
    end
  end

  initial begin
    logic [1:0] ha, hb;
    bit aw;
    reset = 1; start = 0; round_valid = 0; A = 0; B = 0; is_A_win = 0; is_error = 0;
    m_phase = "IDLE";
    model_clear();
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // idle with a round offered: nothing accepted
    step(0, 0, 1, 2'd1, 2'd0, 1, 0);
    step(0, 0, 1, 2'd1, 2'd0, 1, 0);

    // A wins 3-1, then a fifth round is refused
    step(0, 1, 0, 0, 0, 0, 0);
    play(2'd1, 2'd0);
    play(2'd0, 2'd1);
    play(2'd2, 2'd1);
    play(2'd0, 2'd2);
    play(2'd1, 2'd0);
    play(2'd0, 2'd1);

    // draw streak abort
    step(0, 1, 0, 0, 0, 0, 0);
    repeat (4) play(2'd0, 2'd0);
    play(2'd1, 2'd1);

    // B win breaks the streak: no abort after 3+1 draws
    step(0, 1, 0, 0, 0, 0, 0);
    repeat (3) play(2'd0, 2'd0);
    play(2'd0, 2'd1);
    play(2'd2, 2'd2);

    // errors leave scores and streak alone
    step(0, 1, 0, 0, 0, 0, 0);
    repeat (3) play(2'd1, 2'd1);
    step(0, 0, 1, 2'd3, 2'd0, 0, 0);
    step(0, 0, 1, 2'd0, 2'd1, 0, 1);
    play(2'd1, 2'd1);

    // start beats a simultaneous round; reset mid-match
    step(0, 1, 0, 0, 0, 0, 0);
    play(2'd1, 2'd0);
    step(0, 1, 1, 2'd1, 2'd0, 1, 0);
    play(2'd2, 2'd1);
    step(1, 1, 1, 2'd2, 2'd1, 1, 0);
    step(0, 0, 1, 2'd2, 2'd1, 1, 0);

    // history sequence draw, A, B, error
    step(0, 1, 0, 0, 0, 0, 0);
    play(2'd0, 2'd0);
    play(2'd1, 2'd0);
    play(2'd1, 2'd2);
    step(0, 0, 1, 2'd0, 2'd3, 0, 0);

    // error_count saturates
    step(0, 1, 0, 0, 0, 0, 0);
    repeat (SAT + 3) step(0, 0, 1, 2'd2, 2'd0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ha = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      hb = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      aw = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : beats(ha, hb);
      step($urandom_range(0, 99) == 0,
           (m_phase != "PLAY") ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0),
           $urandom_range(0, 4) != 0, ha, hb, aw, $urandom_range(0, 19) == 0);
    end

    step(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
